// File: rtl/fetch_decode_if.sv
// Fetch/decode bus: instruction-memory read port plus the decoded-instruction
// valid/ready channel to execute. master = fetch_decode side.
interface fetch_decode_if #(
    parameter int PC_WIDTH = 8
);
    logic                imem_en;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [15:0]         imem_rdata;
    logic [3:0]          opcode;
    logic [3:0]          dstadd;
    logic [3:0]          srcadd_1;
    logic [3:0]          srcadd_2;
    logic                instr_valid;
    logic                instr_ready;

    modport master (
        output imem_en, imem_addr, opcode, dstadd, srcadd_1, srcadd_2, instr_valid,
        input  imem_rdata, instr_ready
    );

    modport slave (
        input  imem_en, imem_addr, opcode, dstadd, srcadd_1, srcadd_2, instr_valid,
        output imem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_decode.sv
// miniCPU front end: fetch from synchronous imem, decode, issue with valid/ready, HALT.
// Optional macro FETCH_JUMP_EN turns opcode 4'hE into an unissued JMP to {srcadd_1, srcadd_2}.
module fetch_decode #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    fetch_decode_if.master      bus,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_HALTED
    } state_t;

    state_t              r_state, w_next;
    logic [PC_WIDTH-1:0] r_fpc, r_pc;
    logic [3:0]          r_op, r_dst, r_s1, r_s2;
    logic [3:0]          w_op;
    logic                w_is_halt, w_is_jmp;
    logic [PC_WIDTH-1:0] w_jt;

    assign w_op      = bus.imem_rdata[15:12];
    assign w_is_halt = (w_op == 4'hF);
    assign w_jt      = PC_WIDTH'(bus.imem_rdata[7:0]);
`ifdef FETCH_JUMP_EN
    assign w_is_jmp  = (w_op == 4'hE);
`else
    assign w_is_jmp  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (w_is_halt)     w_next = S_HALTED;
                else if (w_is_jmp) w_next = S_FETCH;
                else               w_next = S_ISSUE;
            end
            S_ISSUE:  if (bus.instr_ready) w_next = S_FETCH;
            S_HALTED: if (start) w_next = S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.imem_en     = (r_state == S_FETCH);
        bus.instr_valid = (r_state == S_ISSUE);
        halted          = (r_state == S_HALTED);
    end

    // Fields and pc only move in DECODE, so they hold naturally through ISSUE stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fpc <= RESET_PC;
            r_pc  <= RESET_PC;
            r_op  <= '0;
            r_dst <= '0;
            r_s1  <= '0;
            r_s2  <= '0;
        end else begin
            case (r_state)
                S_DECODE: begin
                    if (w_is_halt) begin
                        r_pc <= r_fpc;
                    end else if (w_is_jmp) begin
                        r_fpc <= w_jt;
                    end else begin
                        r_op  <= bus.imem_rdata[15:12];
                        r_dst <= bus.imem_rdata[11:8];
                        r_s1  <= bus.imem_rdata[7:4];
                        r_s2  <= bus.imem_rdata[3:0];
                        r_pc  <= r_fpc;
                        r_fpc <= r_fpc + 1'b1;
                    end
                end
                S_HALTED: if (start) r_fpc <= RESET_PC;
                default: ;
            endcase
        end
    end

    assign bus.imem_addr = r_fpc;
    assign bus.opcode    = r_op;
    assign bus.dstadd    = r_dst;
    assign bus.srcadd_1  = r_s1;
    assign bus.srcadd_2  = r_s2;
    assign pc            = r_pc;
endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: dut0 with RESET_PC=0, dut1 with RESET_PC=8'hFE for the wrap case.
module tb_fetch_decode;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, start0, rst1, start1, halted0, halted1;
    logic [7:0] pc0, pc1;
    logic [15:0] mem0 [0:255];
    logic [15:0] mem1 [0:255];
    int total = 0;
    int bad   = 0;

    fetch_decode_if #(.PC_WIDTH(8)) bus0();
    fetch_decode_if #(.PC_WIDTH(8)) bus1();

    fetch_decode #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut0 (
        .clk(clk), .reset(rst0), .start(start0), .bus(bus0), .pc(pc0), .halted(halted0));
    fetch_decode #(.PC_WIDTH(8), .RESET_PC(8'hFE)) dut1 (
        .clk(clk), .reset(rst1), .start(start1), .bus(bus1), .pc(pc1), .halted(halted1));

    always @(posedge clk) if (bus0.imem_en) bus0.imem_rdata <= mem0[bus0.imem_addr];
    always @(posedge clk) if (bus1.imem_en) bus1.imem_rdata <= mem1[bus1.imem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] f;
        rst0 = 1'b0; rst1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
        bus0.instr_ready = 1'b1; bus1.instr_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin mem0[i] = 16'hF000; mem1[i] = 16'hF000; end
        tick(); tick();
        f = {bus0.opcode, bus0.dstadd, bus0.srcadd_1, bus0.srcadd_2};
        total++; if ({bus0.imem_en, bus0.instr_valid, halted0} !== 3'b000) begin bad++;
            $display("FAIL rst_ctl got=%b exp=000", {bus0.imem_en, bus0.instr_valid, halted0}); end
        total++; if ({bus0.imem_addr, pc0} !== 16'h0000) begin bad++;
            $display("FAIL rst_addr_pc got=%h exp=0000", {bus0.imem_addr, pc0}); end
        total++; if (f !== 16'h0000) begin bad++;
            $display("FAIL rst_fields got=%h exp=0000", f); end
        total++; if ({bus1.imem_addr, pc1} !== 16'hFEFE) begin bad++;
            $display("FAIL rst1_addr_pc got=%h exp=fefe", {bus1.imem_addr, pc1}); end
    endtask

    task automatic test_program();
        mem0[0] = 16'h1234; mem0[1] = 16'h2567; mem0[2] = 16'hF000;
        rst0 = 1'b1; tick();
        start0 = 1'b1; tick(); start0 = 1'b0;
        total++; if ({bus0.imem_en, bus0.imem_addr} !== 9'h100) begin bad++;
            $display("FAIL prog_fetch0 got=%h exp=100", {bus0.imem_en, bus0.imem_addr}); end
        tick(); tick();
        total++; if ({bus0.instr_valid, bus0.opcode, bus0.dstadd, bus0.srcadd_1, bus0.srcadd_2, pc0} !== 25'h1_1234_00) begin bad++;
            $display("FAIL prog_issue0 got=%h exp=1123400", {bus0.instr_valid, bus0.opcode, bus0.dstadd, bus0.srcadd_1, bus0.srcadd_2, pc0}); end
        tick();
        total++; if ({bus0.instr_valid, bus0.imem_en, bus0.imem_addr} !== 10'h101) begin bad++;
            $display("FAIL prog_fetch1 got=%h exp=101", {bus0.instr_valid, bus0.imem_en, bus0.imem_addr}); end
        tick(); tick();
        total++; if ({bus0.instr_valid, bus0.opcode, bus0.dstadd, bus0.srcadd_1, bus0.srcadd_2, pc0} !== 25'h1_2567_01) begin bad++;
            $display("FAIL prog_issue1 got=%h exp=1256701", {bus0.instr_valid, bus0.opcode, bus0.dstadd, bus0.srcadd_1, bus0.srcadd_2, pc0}); end
        tick(); tick(); tick();
        total++; if ({halted0, bus0.instr_valid, pc0} !== 10'h202) begin bad++;
            $display("FAIL prog_halt got=%h exp=202", {halted0, bus0.instr_valid, pc0}); end
        total++; if ({bus0.opcode, bus0.dstadd, bus0.srcadd_1, bus0.srcadd_2} !== 16'h2567) begin bad++;
            $display("FAIL halt_fields got=%h exp=2567", {bus0.opcode, bus0.dstadd, bus0.srcadd_1, bus0.srcadd_2}); end
        tick(); tick(); tick();
        total++; if ({halted0, bus0.instr_valid, bus0.imem_en} !== 3'b100) begin bad++;
            $display("FAIL halt_stays got=%b exp=100", {halted0, bus0.instr_valid, bus0.imem_en}); end
    endtask

    task automatic test_restart_backpressure();
        start0 = 1'b1; tick(); start0 = 1'b0;
        total++; if ({halted0, bus0.imem_en, bus0.imem_addr} !== 10'h100) begin bad++;
            $display("FAIL restart got=%h exp=100", {halted0, bus0.imem_en, bus0.imem_addr}); end
        bus0.instr_ready = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            total++; if ({bus0.instr_valid, bus0.imem_en, bus0.opcode, bus0.dstadd, bus0.srcadd_1, bus0.srcadd_2, pc0} !== 26'h2_1234_00) begin bad++;
                $display("FAIL stall_%0d got=%h exp=2123400", i, {bus0.instr_valid, bus0.imem_en, bus0.opcode, bus0.dstadd, bus0.srcadd_1, bus0.srcadd_2, pc0}); end
            start0 = (i == 2);
            tick();
        end
        start0 = 1'b0;
        total++; if ({bus0.instr_valid, pc0, bus0.imem_addr} !== 17'h1_0001) begin bad++;
            $display("FAIL stall_hold got=%h exp=10001", {bus0.instr_valid, pc0, bus0.imem_addr}); end
        bus0.instr_ready = 1'b1;
        tick();
        total++; if ({bus0.instr_valid, bus0.imem_en, bus0.imem_addr} !== 10'h101) begin bad++;
            $display("FAIL one_xfer got=%h exp=101", {bus0.instr_valid, bus0.imem_en, bus0.imem_addr}); end
    endtask

    task automatic test_reset_mid();
        bus0.instr_ready = 1'b0;
        tick(); tick();
        total++; if ({bus0.instr_valid, pc0, bus0.imem_addr} !== 17'h1_0102) begin bad++;
            $display("FAIL pre_rst got=%h exp=10102", {bus0.instr_valid, pc0, bus0.imem_addr}); end
        rst0 = 1'b0;
        #2;
        total++; if ({bus0.instr_valid, bus0.imem_addr, pc0, bus0.opcode} !== 21'h0) begin bad++;
            $display("FAIL async_rst got=%h exp=0", {bus0.instr_valid, bus0.imem_addr, pc0, bus0.opcode}); end
        bus0.instr_ready = 1'b1;
        tick(); tick();
        rst0 = 1'b1; tick();
        start0 = 1'b1; tick(); start0 = 1'b0;
        total++; if ({bus0.imem_en, bus0.imem_addr} !== 9'h100) begin bad++;
            $display("FAIL post_rst_fetch got=%h exp=100", {bus0.imem_en, bus0.imem_addr}); end
    endtask

    task automatic test_wrap();
        mem1[8'hFE] = 16'h1ABC; mem1[8'hFF] = 16'h2DEF; mem1[0] = 16'hF000;
        rst1 = 1'b1; tick();
        start1 = 1'b1; tick(); start1 = 1'b0;
        total++; if ({bus1.imem_en, bus1.imem_addr} !== 9'h1FE) begin bad++;
            $display("FAIL wrap_fetch got=%h exp=1fe", {bus1.imem_en, bus1.imem_addr}); end
        tick(); tick();
        total++; if ({bus1.instr_valid, bus1.opcode, bus1.dstadd, bus1.srcadd_1, bus1.srcadd_2, pc1} !== 25'h1_1ABC_FE) begin bad++;
            $display("FAIL wrap_fe got=%h exp=11abcfe", {bus1.instr_valid, bus1.opcode, bus1.dstadd, bus1.srcadd_1, bus1.srcadd_2, pc1}); end
        tick(); tick(); tick();
        total++; if ({bus1.instr_valid, bus1.opcode, bus1.dstadd, bus1.srcadd_1, bus1.srcadd_2, pc1} !== 25'h1_2DEF_FF) begin bad++;
            $display("FAIL wrap_ff got=%h exp=12defff", {bus1.instr_valid, bus1.opcode, bus1.dstadd, bus1.srcadd_1, bus1.srcadd_2, pc1}); end
        tick();
        total++; if ({bus1.imem_en, bus1.imem_addr} !== 9'h100) begin bad++;
            $display("FAIL wrap_00 got=%h exp=100", {bus1.imem_en, bus1.imem_addr}); end
    endtask

    task automatic test_jump();
        logic [23:0] exp_f;
        int          n;
        rst0 = 1'b0; tick();
        mem0[0] = 16'hE042; mem0[1] = 16'hF000; mem0[8'h42] = 16'h3123; mem0[8'h43] = 16'hF000;
        rst0 = 1'b1; tick();
        start0 = 1'b1; tick(); start0 = 1'b0;
`ifdef FETCH_JUMP_EN
        exp_f = {16'h3123, 8'h42};
`else
        exp_f = {16'hE042, 8'h00};
`endif
        n = 0;
        while (bus0.instr_valid !== 1'b1 && n < 20) begin tick(); n++; end
        total++; if (n >= 20) begin bad++;
            $display("FAIL jump_timeout got=%0d cycles exp=<20", n); end
        total++; if ({bus0.opcode, bus0.dstadd, bus0.srcadd_1, bus0.srcadd_2, pc0} !== exp_f) begin bad++;
            $display("FAIL jump_first got=%h exp=%h", {bus0.opcode, bus0.dstadd, bus0.srcadd_1, bus0.srcadd_2, pc0}, exp_f); end
    endtask

    initial begin
        test_reset();
        test_program();
        test_restart_backpressure();
        test_reset_mid();
        test_wrap();
        test_jump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
